// File: rtl/pipeline_pkg.sv
// Shared types and constants for the LEGv8 pipeline MEM stage.
package pipeline_pkg;
    localparam int unsigned DATA_W_DEF = 64;
    localparam logic [4:0]  XZR        = 5'd31;

    typedef enum logic {IDLE, WAIT} mem_state_e;

    // Doubleword accesses must be 8-byte aligned.
    function automatic logic is_misaligned(input logic [2:0] lsb);
        return lsb != 3'b000;
    endfunction
endpackage

// File: rtl/memory_stage_dmem_access_ctrl.sv
// Data-memory req/ack controller: FSM, timeout counter, request latches,
// stall and error generation.
module dmem_access_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              mem_err
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mem_state_e        r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_addr, r_wdata;

    logic w_access, w_misalign, w_expired;

    assign w_access   = mem_read | mem_write;
    assign w_misalign = w_access & is_misaligned(addr[2:0]);
    assign w_expired  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        dmem_req   = 1'b0;
        dmem_we    = mem_write;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        stall      = 1'b0;
        mem_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_misalign) begin
                    mem_err = 1'b1;
                end else if (w_access) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        stall  = 1'b1;
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem_we    = r_we;
                dmem_addr  = r_addr;
                dmem_wdata = r_wdata;
                // The final timeout cycle already has req dropped, so a late ack is ignored.
                if (w_expired) begin
                    mem_err = 1'b1;
                    w_next  = IDLE;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) w_next = IDLE;
                    else          stall  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        if (reset) begin
            dmem_req = 1'b0;
            stall    = 1'b0;
            mem_err  = 1'b0;
            w_next   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt   <= '0;
                r_we    <= mem_write;
                r_addr  <= addr;
                r_wdata <= wdata;
            end else if (w_next == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/memory_stage.sv
// LEGv8 MEM stage: branch resolution, data-memory access and the MEM/WB
// pipeline register with the WB-side forwarding mux.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_MEM,
    input  logic              Branch_MEM,
    input  logic              Uncondbranch_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              Mem2Reg_MEM,
    input  logic              ALUzero_MEM,
    input  logic [4:0]        RD_MEM,
    input  logic [DATA_W-1:0] RegOutB_MEM,
    input  logic [DATA_W-1:0] ALUout_MEM,
    input  logic [DATA_W-1:0] PCtarget_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              PCSrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              stall_MEM,
    output logic              mem_err,
    output logic              regwrite_WB,
    output logic              mem2reg_WB,
    output logic [4:0]        rd_WB,
    output logic [DATA_W-1:0] aluout_WB,
    output logic [DATA_W-1:0] memdata_WB,
    output logic [DATA_W-1:0] memtoregout_WB
);
    logic              w_stall, w_err, w_bubble;
    logic              r_regwrite, r_mem2reg;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_aluout, r_memdata;

    dmem_access_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dmem_ctrl (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (MemRead_MEM),
        .mem_write  (MemWrite_MEM),
        .addr       (ALUout_MEM),
        .wdata      (RegOutB_MEM),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .stall      (w_stall),
        .mem_err    (w_err)
    );

    assign PCSrc         = !reset & (Uncondbranch_MEM | (Branch_MEM & ALUzero_MEM));
    assign branch_target = PCtarget_MEM;
    assign stall_MEM     = w_stall;
    assign mem_err       = w_err;

    // Stalled, misaligned and timed-out cycles all retire nothing into WB.
    assign w_bubble = w_stall | w_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite <= 1'b0;
            r_mem2reg  <= 1'b0;
            r_rd       <= '0;
            r_aluout   <= '0;
            r_memdata  <= '0;
        end else if (w_bubble) begin
            r_regwrite <= 1'b0;
            r_rd       <= XZR;
        end else begin
            r_regwrite <= RegWrite_MEM;
            r_mem2reg  <= Mem2Reg_MEM;
            r_rd       <= RD_MEM;
            r_aluout   <= ALUout_MEM;
            if (MemRead_MEM) r_memdata <= dmem_rdata;
        end
    end

    assign regwrite_WB    = r_regwrite;
    assign mem2reg_WB     = r_mem2reg;
    assign rd_WB          = r_rd;
    assign aluout_WB      = r_aluout;
    assign memdata_WB     = r_memdata;
    assign memtoregout_WB = r_mem2reg ? r_memdata : r_aluout;
endmodule
